// File: rtl/fft_sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage: buffers the first half of each
// N-sample block, then emits halved sums while storing halved differences for the next block.
module fft_sdf_butterfly #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic [AW-1:0]    tw_idx,
  output logic             out_sof
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] dl_r_q [DEPTH];
  logic [WIDTH-1:0] dl_i_q [DEPTH];

  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic [WIDTH-1:0] out_r_q, out_r_d;
  logic [WIDTH-1:0] out_i_q, out_i_d;
  logic [AW-1:0]    tw_q, tw_d;

  logic             phase;
  logic [WIDTH-1:0] head_r, head_i;
  logic [WIDTH:0]   sum_r, sum_i, diff_r, diff_i;
  logic [WIDTH-1:0] wr_r, wr_i;

  assign phase  = cnt_q[CW-1];
  assign head_r = dl_r_q[DEPTH-1];
  assign head_i = dl_i_q[DEPTH-1];

  // One extra bit of headroom makes the halved result always fit back into WIDTH.
  assign sum_r  = {head_r[WIDTH-1], head_r} + {in_r[WIDTH-1], in_r};
  assign sum_i  = {head_i[WIDTH-1], head_i} + {in_i[WIDTH-1], in_i};
  assign diff_r = {head_r[WIDTH-1], head_r} - {in_r[WIDTH-1], in_r};
  assign diff_i = {head_i[WIDTH-1], head_i} - {in_i[WIDTH-1], in_i};

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    tw_d        = tw_q;
    wr_r        = in_r;
    wr_i        = in_i;
    if (in_valid) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == '1) primed_d = 1'b1;
      if (phase) begin
        out_r_d     = WIDTH'(sum_r >> 1);
        out_i_d     = WIDTH'(sum_i >> 1);
        tw_d        = '0;
        wr_r        = WIDTH'(diff_r >> 1);
        wr_i        = WIDTH'(diff_i >> 1);
        out_valid_d = 1'b1;
        out_sof_d   = (cnt_q[AW-1:0] == '0);
      end else begin
        out_r_d     = head_r;
        out_i_d     = head_i;
        tw_d        = cnt_q[AW-1:0];
        out_valid_d = primed_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      tw_q        <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dl_r_q[k] <= '0;
        dl_i_q[k] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      tw_q        <= tw_d;
      if (in_valid) begin
        dl_r_q[0] <= wr_r;
        dl_i_q[0] <= wr_i;
        for (int k = 1; k < DEPTH; k++) begin
          dl_r_q[k] <= dl_r_q[k-1];
          dl_i_q[k] <= dl_i_q[k-1];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign tw_idx    = tw_q;

endmodule
